// File: rtl/param_stack.sv
// Parametrised LIFO with registered top-of-stack, replace-top on push+pop,
// occupancy status and sticky error flags. Optional STACK_WATERMARK_EN adds a high-water mark.
module param_stack #(
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 16,
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_enable,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop_enable,
  output logic [DATA_W-1:0] pop_data,
  output logic [CNT_W-1:0]  count,
  output logic              empty,
  output logic              full,
  input  logic              err_clear,
  output logic              overflow,
  output logic              underflow,
  output logic [CNT_W-1:0]  watermark
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic [1:0] {
    OP_HOLD = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_REPL = 2'b11
  } op_e;

  op_e               op;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] top_q, top_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              empty_w, full_w;
  logic              wr_en;
  logic [PTR_W-1:0]  wr_addr;
  logic [PTR_W-1:0]  push_idx, top_idx, below_idx;

  assign op      = op_e'({push_enable, pop_enable});
  assign empty_w = (count_q == '0);
  assign full_w  = (count_q == CNT_W'(DEPTH));

  // The count doubles as the write pointer: entries live in mem_q[0 .. count_q-1].
  assign push_idx  = PTR_W'(count_q);
  assign top_idx   = PTR_W'(count_q - CNT_W'(1));
  assign below_idx = PTR_W'(count_q - CNT_W'(2));

  // NOTE: every signal assigned here gets a default first so no latch is inferred.
  always_comb begin
    count_d = count_q;
    top_d   = top_q;
    ovf_d   = ovf_q & ~err_clear;
    unf_d   = unf_q & ~err_clear;
    wr_en   = 1'b0;
    wr_addr = push_idx;
    case (op)
      OP_PUSH: begin
        if (full_w) begin
          ovf_d = 1'b1;
        end else begin
          wr_en   = 1'b1;
          count_d = count_q + CNT_W'(1);
          top_d   = push_data;
        end
      end
      OP_POP: begin
        if (empty_w) begin
          unf_d = 1'b1;
        end else begin
          count_d = count_q - CNT_W'(1);
          top_d   = (count_q == CNT_W'(1)) ? '0 : mem_q[below_idx];
        end
      end
      OP_REPL: begin
        // Replace-top never changes occupancy; on an empty stack it degrades to a plain push.
        wr_en = 1'b1;
        top_d = push_data;
        if (empty_w) begin
          unf_d   = 1'b1;
          count_d = CNT_W'(1);
        end else begin
          wr_addr = top_idx;
        end
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
      top_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      top_q   <= top_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // NOTE: storage is not reset; stale entries are unreachable once count_q is cleared.
  always_ff @(posedge clk) begin
    if (wr_en && rst) begin
      mem_q[wr_addr] <= push_data;
    end
  end

`ifdef STACK_WATERMARK_EN
  logic [CNT_W-1:0] wm_q, wm_d;

  always_comb begin
    wm_d = wm_q;
    if (err_clear) begin
      wm_d = count_d;
    end else if (count_d > wm_q) begin
      wm_d = count_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wm_q <= '0;
    end else begin
      wm_q <= wm_d;
    end
  end

  assign watermark = wm_q;
`else
  assign watermark = '0;
`endif

  assign pop_data  = top_q;
  assign count     = count_q;
  assign empty     = empty_w;
  assign full      = full_w;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

// File: tb/tb_param_stack.sv
// Self-checking bench for param_stack (DEPTH=4, DATA_W=8): directed sequence then random
// traffic, compared against a queue-based reference model through a scoreboard.
module tb_param_stack;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic              clk;
  logic              rst;
  logic              push_enable;
  logic [DATA_W-1:0] push_data;
  logic              pop_enable;
  logic [DATA_W-1:0] pop_data;
  logic [CNT_W-1:0]  count;
  logic              empty;
  logic              full;
  logic              err_clear;
  logic              overflow;
  logic              underflow;
  logic [CNT_W-1:0]  watermark;

  param_stack #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .push_enable(push_enable),
    .push_data  (push_data),
    .pop_enable (pop_enable),
    .pop_data   (pop_data),
    .count      (count),
    .empty      (empty),
    .full       (full),
    .err_clear  (err_clear),
    .overflow   (overflow),
    .underflow  (underflow),
    .watermark  (watermark)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0] pd;
    logic [CNT_W-1:0]  cnt;
    logic              emp;
    logic              ful;
    logic              ovf;
    logic              unf;
    logic [CNT_W-1:0]  wm;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: the stack is a plain queue, top at the back.
  logic [DATA_W-1:0] stk[$];
  bit                m_ovf;
  bit                m_unf;
  int                m_wm;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic push_expected();
    exp_t e;
    e.pd  = (stk.size() > 0) ? stk[stk.size()-1] : '0;
    e.cnt = CNT_W'(stk.size());
    e.emp = (stk.size() == 0);
    e.ful = (stk.size() == DEPTH);
    e.ovf = m_ovf;
    e.unf = m_unf;
`ifdef STACK_WATERMARK_EN
    e.wm  = CNT_W'(m_wm);
`else
    e.wm  = '0;
`endif
    exp_q.push_back(e);
  endtask

  task automatic model_op(input bit p, input bit q, input logic [DATA_W-1:0] d, input bit clr);
    if (clr) begin
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end
    if (p && q) begin
      if (stk.size() == 0) begin
        m_unf = 1'b1;
        stk.push_back(d);
      end else begin
        stk[stk.size()-1] = d;
      end
    end else if (p) begin
      if (stk.size() == DEPTH) m_ovf = 1'b1;
      else stk.push_back(d);
    end else if (q) begin
      if (stk.size() == 0) m_unf = 1'b1;
      else void'(stk.pop_back());
    end
    if (clr) m_wm = stk.size();
    else if (stk.size() > m_wm) m_wm = stk.size();
  endtask

  task automatic step(input bit p, input bit q, input logic [DATA_W-1:0] d, input bit clr);
    @(negedge clk);
    rst         = 1'b1;
    push_enable = p;
    pop_enable  = q;
    push_data   = d;
    err_clear   = clr;
    model_op(p, q, d, clr);
    push_expected();
  endtask

  // Reset lands mid-cycle while a push is being presented.
  task automatic apply_reset(input logic [DATA_W-1:0] d);
    @(negedge clk);
    push_enable = 1'b1;
    pop_enable  = 1'b0;
    push_data   = d;
    err_clear   = 1'b0;
    #2 rst = 1'b0;
    stk.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    m_wm  = 0;
    push_expected();
  endtask

  // Monitor: each edge that has a pending expectation is compared after outputs settle.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("pop_data",  32'(pop_data),  32'(e.pd));
        check("count",     32'(count),     32'(e.cnt));
        check("empty",     32'(empty),     32'(e.emp));
        check("full",      32'(full),      32'(e.ful));
        check("overflow",  32'(overflow),  32'(e.ovf));
        check("underflow", 32'(underflow), 32'(e.unf));
        check("watermark", 32'(watermark), 32'(e.wm));
      end
    end
  end

  initial begin
    rst         = 1'b0;
    push_enable = 1'b0;
    pop_enable  = 1'b0;
    push_data   = '0;
    err_clear   = 1'b0;
    m_ovf       = 1'b0;
    m_unf       = 1'b0;
    m_wm        = 0;
    repeat (2) @(posedge clk);
    apply_reset(8'h5A);
    step(0, 0, 8'h00, 0);

    // Fill, overflow, drain, underflow.
    step(1, 0, 8'h11, 0);
    step(1, 0, 8'h22, 0);
    step(1, 0, 8'h33, 0);
    step(1, 0, 8'h44, 0);
    step(1, 0, 8'h55, 0);
    repeat (4) step(0, 1, 8'h00, 0);
    step(0, 1, 8'h00, 0);

    // Replace-top at count 1 and at full; replace on empty.
    step(0, 0, 8'h00, 1);
    step(1, 0, 8'hA0, 0);
    step(1, 1, 8'hB0, 0);
    step(1, 0, 8'hA1, 0);
    step(1, 0, 8'hA2, 0);
    step(1, 0, 8'hA3, 0);
    step(1, 1, 8'hB3, 0);
    repeat (4) step(0, 1, 8'h00, 0);
    step(1, 1, 8'hC3, 0);
    step(0, 0, 8'h00, 1);
    step(0, 1, 8'h00, 0);
    step(0, 1, 8'h00, 1);
    step(0, 1, 8'h00, 0);
    step(0, 1, 8'h00, 1);

    // Watermark scenario followed by reset during a push.
    apply_reset(8'h77);
    step(1, 0, 8'h01, 0);
    step(1, 0, 8'h02, 0);
    step(1, 0, 8'h03, 0);
    step(0, 1, 8'h00, 0);
    step(0, 1, 8'h00, 0);
    step(0, 0, 8'h00, 1);
    step(1, 0, 8'h04, 0);
    apply_reset(8'h99);

    // Random traffic with occasional error clears and resets.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(99) == 0) begin
        apply_reset(8'($urandom));
      end else begin
        step(1'($urandom_range(1)), 1'($urandom_range(1)), 8'($urandom),
             ($urandom_range(15) == 0));
      end
    end
    step(0, 0, 8'h00, 0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #3;
    check("drain", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
